// File: rtl/dsm_dec_pkg.sv
// dsm_dec_pkg: shared CIC constants, width/shift helpers and signed saturation for dsm_bitstream_decimator
package dsm_dec_pkg;
  localparam int CIC_ORDER = 3;
  function automatic int cic_width(input int decim);
    return 2 + CIC_ORDER * $clog2(decim);
  endfunction
  function automatic int out_shift(input int decim, input int out_width);
    return CIC_ORDER * $clog2(decim) + 1 - out_width;
  endfunction
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    return v > hi ? hi : v < -hi - 64'sd1 ? -hi - 64'sd1 : v;
  endfunction
endpackage

// File: rtl/dsm_dec_integrator.sv
// dsm_dec_integrator: en-gated W-bit wrapping accumulator (clk, rst, en, din -> acc registered, nxt = acc + din)
module dsm_dec_integrator #(
  parameter int W = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic signed [W-1:0] din,
  output logic signed [W-1:0] acc,
  output logic signed [W-1:0] nxt
);
  assign nxt = acc + din;
  always_ff @(posedge clk)
    if (rst) acc <= '0;
    else if (en) acc <= nxt;
endmodule

// File: rtl/dsm_bitstream_decimator.sv
// dsm_bitstream_decimator: sinc3 decimator, 1-bit DSM stream to signed PCM (clk, rst, en, bit_i -> sample_o, valid_o); DSM_DEC_DCBLOCK_EN adds a DC blocker
module dsm_bitstream_decimator
  import dsm_dec_pkg::*;
#(
  parameter int DECIM     = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        bit_i,
  output logic signed [OUT_WIDTH-1:0] sample_o,
  output logic                        valid_o
);
  localparam int B  = cic_width(DECIM);
  localparam int SH = out_shift(DECIM, OUT_WIDTH);
  localparam int CW = $clog2(DECIM);
  logic signed [B-1:0] x, i3, c1, c2, c3, d1, d2, d3, c3_q, scaled;
  logic signed [B-1:0] din [CIC_ORDER];
  logic signed [B-1:0] acc [CIC_ORDER];
  logic signed [B-1:0] nxt [CIC_ORDER];
  logic [CW-1:0] cnt;
  logic tick, tick_q, comb_v;
  logic signed [OUT_WIDTH-1:0] pcm;
  assign x = bit_i ? B'(1) : '1;
  assign din[0] = x;
  for (genvar k = 0; k < CIC_ORDER; k++) begin : g_int
    if (k > 0) begin : g_link
      assign din[k] = nxt[k-1];
    end
    dsm_dec_integrator #(.W(B)) u_int (
      .clk(clk),
      .rst(rst),
      .en(en),
      .din(din[k]),
      .acc(acc[k]),
      .nxt(nxt[k])
    );
  end
  assign i3 = acc[CIC_ORDER-1];
  assign tick = en && cnt == CW'(DECIM - 1);
  assign c1 = i3 - d1;
  assign c2 = c1 - d2;
  assign c3 = c2 - d3;
  assign scaled = c3_q >>> SH;
  assign pcm = OUT_WIDTH'(sat_signed(64'(scaled), OUT_WIDTH));
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      tick_q <= 1'b0;
      comb_v <= 1'b0;
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
      c3_q <= '0;
    end else begin
      if (en) cnt <= cnt + 1'b1;
      tick_q <= tick;
      comb_v <= tick_q;
      if (tick_q) begin
        d1 <= i3;
        d2 <= c1;
        d3 <= c2;
        c3_q <= c3;
      end
    end
`ifdef DSM_DEC_DCBLOCK_EN
  localparam int DW = OUT_WIDTH + 2;
  logic signed [OUT_WIDTH-1:0] s_q, xp;
  logic s_v;
  logic signed [DW-1:0] y;
  assign y = DW'(s_q) - DW'(xp) + DW'(sample_o) - DW'(sample_o >>> 8);
  always_ff @(posedge clk)
    if (rst) begin
      s_q <= '0;
      s_v <= 1'b0;
      xp <= '0;
      sample_o <= '0;
      valid_o <= 1'b0;
    end else begin
      s_v <= comb_v;
      valid_o <= s_v;
      if (comb_v) s_q <= pcm;
      if (s_v) begin
        xp <= s_q;
        sample_o <= OUT_WIDTH'(sat_signed(64'(y), OUT_WIDTH));
      end
    end
`else
  always_ff @(posedge clk)
    if (rst) begin
      sample_o <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= comb_v;
      if (comb_v) sample_o <= pcm;
    end
`endif
endmodule

// File: doc/dsm_bitstream_decimator.md
# dsm_bitstream_decimator

Third-order CIC (sinc³) decimator that turns a 1-bit delta-sigma bitstream into signed PCM samples. It is the receiving end of the DSM DAC's modulator output. It sits on the 50 MHz domain next to the DAC toplevel, and its samples can be shown on HEX0/HEX1 or sent over UART. It also serves as the loop-back checker for the DAC path.

## Interface
- DECIM, 64: decimation ratio R; power of two, 4..1024.
- OUT_WIDTH, 16: signed output sample width; must be ≤ 1 + 3·log2(DECIM).
- clk  in  1  system clock (CLOCK_50_B5B domain).
- rst  in  1  reset; synchronous, active-high.
- en  in  1  bit strobe; bit_i is consumed only on cycles with en=1.
- bit_i  in  1  modulator bit; 1 → +1, 0 → −1.
- sample_o  out  OUT_WIDTH  signed decimated sample; holds between valid pulses.
- valid_o  out  1  one-cycle pulse per new sample_o.

## Operation
- Input mapping: bit_i is mapped to the 2-bit signed value +1/−1.
- Internal width: B = 2 + 3·log2(DECIM), all stages signed B bits (20 bits at R=64).
- Integrators (3 cascaded):
  - Update only when en=1: i1 += x, i2 += i1, i3 += i2.
  - Modulo-2^B wrap-around is intended and must not be detected or saturated.
- Decimation counter:
  - Counts en cycles 0..DECIM−1 and wraps.
  - en=1 with counter = DECIM−1 raises the internal tick for one cycle.
- Combs (3 cascaded, differential delay 1):
  - Evaluated on the cycle after the tick, from the registered i3 that includes the R-th bit.
  - c1 = i3 − d1, c2 = c1 − d2, c3 = c2 − d3; delay registers d1..d3 update only then.
  - All subtractions are modulo 2^B.
- Output scaling:
  - Steady-state c3 lies in [−R³, +R³].
  - sample_o = c3 arithmetically shifted right by (log2(R³) + 1 − OUT_WIDTH).
  - Saturate to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]. Only +full-scale saturates: all-ones gives 32767, all-zeros gives −32768 at defaults.
- en=0: all state holds; no valid_o is generated.
- Transient: the first 3 samples after reset are filter warm-up. They are still flagged valid; the consumer discards them.

## Timing
- Reset values: sample_o=0, valid_o=0, all integrators, comb delays and counter = 0. rst has priority over en.
- Latency: valid_o and the new sample_o appear together, registered, on the 2nd rising edge after the edge that samples the DECIM-th en bit.
- Throughput: exactly one valid_o per DECIM en-qualified bits, regardless of en duty cycle.
- Minimum en spacing is 1 (en tied high is legal); valid pulses are then DECIM cycles apart.
- Simultaneous events:
  - en with tick while the comb from the previous tick is still evaluating cannot collide, since DECIM ≥ 4.
  - A new bit arriving on the comb-evaluate cycle is integrated normally.
- rst mid-frame: counter, integrators and combs clear; any pending valid is dropped. The next sample requires a full DECIM bits.

## Configuration
- DSM_DEC_DCBLOCK_EN defined: a first-order DC blocker follows the scaler.
  - y[n] = x[n] − x[n−1] + y[n−1] − (y[n−1] >>> 8), computed at OUT_WIDTH+2 bits, saturated to OUT_WIDTH.
  - Adds exactly 1 cycle of latency to valid_o/sample_o.
  - Reset state x[n−1] = y[n−1] = 0.
- Undefined: no blocker; sample_o carries DC, with latency as in Timing.

## Structure
- Package dsm_dec_pkg:
  - CIC_ORDER = 3.
  - Function cic_width(decim) returning B.
  - Function out_shift(decim, out_width).
  - Saturation function sat_signed.
- Sub-module dsm_dec_integrator: one en-gated B-bit accumulator, instantiated 3×. Combs, counter, scaler and DC blocker stay in the top module.

## Test plan
- bit_i=1 constant, en=1, R=64 → from the 4th valid on, sample_o = 32767 every 64 cycles; valid_o is a single-cycle pulse.
- bit_i=0 constant → sample_o = −32768 from the 4th valid.
- Alternating 1010…, and 75 % ones (1110 repeating) → 0 and +16384 respectively, after warm-up.
- en=1 every 4th cycle, all ones → same values; valid_o spacing is 256 cycles; state unchanged on en=0 cycles.
- rst pulsed for 1 cycle at bit 30 of a frame → outputs 0 next cycle; first valid 64 en-bits after rst release.
- DSM_DEC_DCBLOCK_EN, all ones → first post-warm-up sample is near 32767, then decays monotonically toward 0; latency is one cycle longer than without the macro.
